mult_acc: RTL and testbench
===========================

MULT_ACC -- requirements
Module: mult_acc

Interface
REQ-001 Parameter ACC_W, default 24: accumulator and result width in bits, two's complement, legal range 18..32.
REQ-002 Parameter LEN_W, default 8: width of the product-count field.
REQ-003 Port clk  input  1: the single clock, rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Port start  input  1: begin a new accumulation frame; honoured only in IDLE.
REQ-006 Port cfg_len  input  LEN_W: number of products in the frame; sampled when start is honoured.
REQ-007 Port in_valid  input  1: in_product is valid.
REQ-008 Port in_ready  output  1: block accepts a product this cycle.
REQ-009 Port in_product  input  17: multiplier result, sign-magnitude; bit 16 is the sign, bits 15:0 are the magnitude.
REQ-010 Port out_valid  output  1: out_sum is valid.
REQ-011 Port out_ready  input  1: consumer accepts out_sum.
REQ-012 Port out_sum  output  ACC_W: accumulated frame sum, two's complement.
REQ-013 Port out_ovf  output  1: frame overflowed; behaviour is defined in REQ-028 and REQ-029.
REQ-014 Port busy  output  1: FSM is not in IDLE.

Function
REQ-015 FSM states shall be IDLE, ACC and DONE.
- IDLE to ACC: start=1 and cfg_len!=0.
- IDLE to DONE: start=1 and cfg_len==0, with out_sum=0.
- ACC to DONE: the final product handshake completes.
- DONE to IDLE: out_valid & out_ready.
REQ-016 On a frame start, the accumulator shall clear to 0, out_ovf shall clear, and the remaining-count register shall load cfg_len.
REQ-017 in_ready shall be 1 only in ACC; a product transfers on in_valid & in_ready.
REQ-018 Each transferred product shall be converted to two's complement (sign ? -mag : mag), sign-extended to ACC_W, and added into the accumulator in the same cycle.
REQ-019 Negative zero (sign=1, magnitude=0) shall contribute 0.
REQ-020 The remaining count shall decrement by 1 per transfer; the transfer that takes it from 1 to 0 shall be the last one of the frame.
REQ-021 out_valid shall assert on the first cycle after the last transfer (latency 1) and shall hold, with out_sum and out_ovf stable, until out_ready is sampled high.
REQ-022 While in ACC, a gap cycle (in_valid=0) shall leave the accumulator and the count unchanged.
REQ-023 start shall be ignored in ACC and DONE; a new frame may start on the cycle after the DONE-to-IDLE transition.
REQ-024 busy shall be 1 in ACC and DONE.

Reset
REQ-025 When rst_n=0 at a clock edge, the block shall enter IDLE. The following outputs shall be 0: in_ready, out_valid, out_sum, out_ovf and busy. The accumulator and the count shall also be 0.
REQ-026 A reset in the middle of a frame shall abandon that frame; no out_valid shall be produced for it.
REQ-027 The first start is honoured on the first cycle that rst_n=1.

Configuration
REQ-028 With macro MULT_ACC_SAT_EN defined:
- If an addition exceeds the signed ACC_W range, the accumulator shall saturate at 2^(ACC_W-1)-1 or -2^(ACC_W-1).
- out_ovf shall become 1 and stay 1 (sticky) until the next frame start.
- A saturated accumulator shall still move toward zero when an opposite-sign product is added.
REQ-029 Without MULT_ACC_SAT_EN:
- Additions shall wrap modulo 2^ACC_W.
- out_ovf shall be constant 0.

Structure
REQ-030 A shared package mult_pkg shall hold:
- the state enum;
- PROD_W=17;
- PROD_SIGN_BIT=16;
- the ACC_W default value.
REQ-031 Sign-magnitude to two's-complement conversion shall be a separate sub-module, mult_sm2tc. It is combinational, parameterised on output width, and instantiated once.

Verification
REQ-032 Frame start=1, cfg_len=3, products +100, -30, +5 with no gaps -> out_valid on the cycle after the third transfer, out_sum=75, out_ovf=0.
REQ-033 Frame cfg_len=2, products 0x10000 (negative zero) and +7, with in_valid low for 3 cycles between them -> out_sum=7; in_ready stays 1 throughout ACC.
REQ-034 start with cfg_len=0 -> out_valid on the next cycle, out_sum=0; hold out_ready=0 for 4 cycles -> out_valid and out_sum remain stable.
REQ-035 With ACC_W=18, a frame of 3 products of magnitude 0xFFFF, all positive:
- with MULT_ACC_SAT_EN defined -> out_sum=131071, out_ovf=1;
- without the macro -> wrapped value -65539 mod 2^18 (out_sum=0x2FFFD), out_ovf=0.
REQ-036 rst_n=0 after 2 of 4 transfers, then a new frame cfg_len=1, product -9 -> no out_valid for the abandoned frame; out_sum=-9.
REQ-037 start asserted during ACC and during DONE -> ignored; frame count and out_sum unaffected.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the mult_acc accumulator block.
package mult_pkg;
    localparam int PROD_W        = 17;
    localparam int PROD_SIGN_BIT = 16;
    localparam int ACC_W_DEF     = 24;
    localparam int LEN_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/mult_acc_if.sv
// Frame control, product input stream and result output stream of mult_acc.
interface mult_acc_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [16:0]       in_product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    modport master (
        output start, cfg_len, in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );
    modport slave (
        input  start, cfg_len, in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/mult_sm2tc.sv
// Sign-magnitude product to sign-extended two's complement; -0 maps to 0.
module mult_sm2tc
    import mult_pkg::*;
#(
    parameter int OUT_W = ACC_W_DEF
) (
    input  logic [PROD_W-1:0] prod_i,
    output logic [OUT_W-1:0]  tc_o
);
    logic [OUT_W-1:0] mag_ext;

    assign mag_ext = OUT_W'(prod_i[PROD_SIGN_BIT-1:0]);
    assign tc_o    = prod_i[PROD_SIGN_BIT] ? (~mag_ext + 1'b1) : mag_ext;
endmodule

// File: rtl/mult_acc.sv
// Framed signed accumulator of sign-magnitude products.
// Optional saturation with sticky overflow flag: define MULT_ACC_SAT_EN.
module mult_acc
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    mult_acc_if.slave bus
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] prod_tc, sum_raw, sum_add;
    logic             xfer, frame_start, add_ovf;

    mult_sm2tc #(.OUT_W(ACC_W)) u_sm2tc (
        .prod_i (bus.in_product),
        .tc_o   (prod_tc)
    );

    assign xfer        = (state_q == ACC) && bus.in_valid;
    assign frame_start = (state_q == IDLE) && bus.start;
    assign sum_raw     = acc_q + prod_tc;
    // Signed overflow: operands agree in sign, result does not.
    assign add_ovf     = (acc_q[ACC_W-1] == prod_tc[ACC_W-1]) &&
                         (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MULT_ACC_SAT_EN
    logic ovf_q, ovf_d;

    assign sum_add = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;

    always_comb begin
        ovf_d = ovf_q;
        if (frame_start)
            ovf_d = 1'b0;
        else if (xfer && add_ovf)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.out_ovf = ovf_q;
`else
    assign sum_add     = sum_raw;
    assign bus.out_ovf = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    cnt_d   = bus.cfg_len;
                    state_d = (bus.cfg_len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_d = sum_add;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = acc_q;
endmodule

// File: tb/tb_mult_acc.sv
// Directed scoreboard bench for mult_acc (24-bit main instance, 18-bit overflow instance).
module tb_mult_acc;
    import mult_pkg::*;

    typedef struct {
        logic [23:0] sum;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mult_acc_if #(.ACC_W(24), .LEN_W(8)) bus  ();
    mult_acc_if #(.ACC_W(18), .LEN_W(8)) bus2 ();

    mult_acc #(.ACC_W(24), .LEN_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mult_acc #(.ACC_W(18), .LEN_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int v, input logic o);
        exp_t e;
        e.sum = 24'(v);
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic start_frame(input logic [7:0] len);
        bus.start   = 1'b1;
        bus.cfg_len = len;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic send(input logic [16:0] p);
        int n = 0;
        bus.in_valid   = 1'b1;
        bus.in_product = p;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("send_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   n = 0;
        exp_t e;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_sum"},   32'(bus.out_sum),   32'(e.sum));
            chk({tag, "_ovf"},   32'(bus.out_ovf),   32'(e.ovf));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 0;  bus.cfg_len = 0;  bus.in_valid = 0;  bus.in_product = 0;  bus.out_ready = 0;
        bus2.start = 0; bus2.cfg_len = 0; bus2.in_valid = 0; bus2.in_product = 0; bus2.out_ready = 0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
        chk("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);

        // start on the first cycle out of reset: +100, -30, +5
        push_exp(75, 1'b0);
        rst_n = 1'b1;
        start_frame(8'd3);
        chk("f1_busy", 32'(bus.busy), 32'd1);
        send({1'b0, 16'd100});
        send({1'b1, 16'd30});
        send({1'b0, 16'd5});
        chk("f1_latency", 32'(bus.out_valid), 32'd1);
        collect("f1");

        // negative zero, 3 gap cycles, +7
        push_exp(7, 1'b0);
        start_frame(8'd2);
        send(17'h10000);
        for (int i = 0; i < 3; i++) begin
            chk("f2_gap_ready", 32'(bus.in_ready), 32'd1);
            @(negedge clk);
        end
        chk("f2_gap_sum", 32'(bus.out_sum), 32'd0);
        send({1'b0, 16'd7});
        collect("f2");

        // zero-length frame, consumer stalls 4 cycles
        push_exp(0, 1'b0);
        start_frame(8'd0);
        for (int i = 0; i < 4; i++) begin
            chk("f3_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("f3_hold_sum",   32'(bus.out_sum),   32'd0);
            @(negedge clk);
        end
        collect("f3");

        // 18-bit instance: 3 x +0xFFFF overflows the signed range
        bus2.start   = 1'b1;
        bus2.cfg_len = 8'd3;
        @(negedge clk);
        bus2.start      = 1'b0;
        bus2.in_valid   = 1'b1;
        bus2.in_product = 17'h0FFFF;
        repeat (3) @(negedge clk);
        bus2.in_valid = 1'b0;
        chk("w18_valid", 32'(bus2.out_valid), 32'd1);
`ifdef MULT_ACC_SAT_EN
        chk("w18_sum", 32'(bus2.out_sum), 32'd131071);
        chk("w18_ovf", 32'(bus2.out_ovf), 32'd1);
`else
        chk("w18_sum", 32'(bus2.out_sum), 32'h2FFFD);
        chk("w18_ovf", 32'(bus2.out_ovf), 32'd0);
`endif
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        chk("w18_idle", 32'(bus2.busy), 32'd0);

        // reset after 2 of 4 transfers abandons the frame
        start_frame(8'd4);
        send({1'b0, 16'd50});
        send({1'b0, 16'd60});
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_mid_busy",  32'(bus.busy),      32'd0);
        end
        chk("rst_mid_sum", 32'(bus.out_sum), 32'd0);
        rst_n = 1'b1;
        push_exp(-9, 1'b0);
        start_frame(8'd1);
        send({1'b1, 16'd9});
        collect("f5");

        // start during ACC and DONE is ignored
        push_exp(30, 1'b0);
        start_frame(8'd2);
        start_frame(8'd0);
        chk("f6_acc_busy",  32'(bus.busy),      32'd1);
        chk("f6_acc_valid", 32'(bus.out_valid), 32'd0);
        send({1'b0, 16'd10});
        chk("f6_mid_valid", 32'(bus.out_valid), 32'd0);
        send({1'b0, 16'd20});
        start_frame(8'd5);
        chk("f6_done_valid", 32'(bus.out_valid), 32'd1);
        chk("f6_done_sum",   32'(bus.out_sum),   32'd30);
        collect("f6");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
